// File: rtl/mat_packet_sequencer.sv
// mat_packet_sequencer
// Per-packet controller for the MAT ingress path. Captures the first
// HEADER_BEATS ingress beats into the header buffer, waits for the
// dispatcher's drop decision, then either replays the buffered header and
// passes the remainder through, or flushes the buffer and discards the
// remainder. The 3-bit state is shared with the dispatcher and parser.
//
// Handshakes: every port pair (in_*, m_axis_*) follows AXI-Stream rules. A
// beat moves on a rising clk edge where valid && ready. Valid never depends
// on ready of the same port. The only ready-to-ready path is
// m_axis_tready -> in_tready while the remainder streams through.
module mat_packet_sequencer #(
  parameter int unsigned HEADER_BEATS     = 5,
  // Counter reset values; 0 in normal use.
  parameter logic [31:0] PKT_COUNT_RESET  = '0,
  parameter logic [31:0] DROP_COUNT_RESET = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        in_tvalid,
  input  logic        in_tlast,
  output logic        in_tready,
  input  logic        drop,
  output logic        hdr_wr,
  output logic        hdr_rd,
  output logic        hdr_sel,
  output logic        hdr_flush,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [2:0]  state,
  output logic        busy,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count
);

  typedef enum logic [2:0] {
    IDLE               = 3'd0,
    PARSE_DATA         = 3'd1,
    CONTROL            = 3'd2,
    SEND_ANALYSED_DATA = 3'd3,
    SEND_REMAIN        = 3'd4,
    DROP               = 3'd5
  } state_t;

  localparam logic [3:0] HDR_LAST = 4'(HEADER_BEATS);

  state_t      state_q;
  logic [3:0]  hdr_cnt;     // header beats captured so far
  logic [3:0]  rep_cnt;     // header beats still to replay
  logic        ctl_cnt;     // 0 = first CONTROL cycle, 1 = decision cycle
  logic        short_pkt;   // whole packet fitted in the header window
  logic        flush_q;
  logic [31:0] pkt_cnt_q;
  logic [31:0] drop_cnt_q;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_tvalid && in_tready;
  assign out_xfer = m_axis_tvalid && m_axis_tready;

  // Handshake and buffer-control decode from the registered state.
  always_comb begin
    in_tready     = 1'b0;
    hdr_wr        = 1'b0;
    hdr_rd        = 1'b0;
    hdr_sel       = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      PARSE_DATA: begin
        in_tready = 1'b1;
        hdr_wr    = in_tvalid;
      end
      SEND_ANALYSED_DATA: begin
        hdr_sel       = 1'b1;
        m_axis_tvalid = (rep_cnt != 4'd0);
        m_axis_tlast  = short_pkt && (rep_cnt == 4'd1);
        hdr_rd        = (rep_cnt != 4'd0) && m_axis_tready;
      end
      SEND_REMAIN: begin
        in_tready     = m_axis_tready;
        m_axis_tvalid = in_tvalid;
        m_axis_tlast  = in_tlast;
      end
      DROP: begin
        // A short packet has nothing left on the ingress side to discard.
        in_tready = !short_pkt;
      end
      default: ;
    endcase
  end

  // Packet FSM, per-packet counters and statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hdr_cnt    <= 4'd0;
      rep_cnt    <= 4'd0;
      ctl_cnt    <= 1'b0;
      short_pkt  <= 1'b0;
      flush_q    <= 1'b0;
      pkt_cnt_q  <= PKT_COUNT_RESET;
      drop_cnt_q <= DROP_COUNT_RESET;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && in_tvalid) begin
            state_q   <= PARSE_DATA;
            hdr_cnt   <= 4'd0;
            short_pkt <= 1'b0;
          end
        end
        PARSE_DATA: begin
          if (in_xfer) begin
            hdr_cnt <= hdr_cnt + 4'd1;
            if (in_tlast) begin
              short_pkt <= 1'b1;
              ctl_cnt   <= 1'b0;
              state_q   <= CONTROL;
            end else if (hdr_cnt + 4'd1 == HDR_LAST) begin
              ctl_cnt <= 1'b0;
              state_q <= CONTROL;
            end
          end
        end
        CONTROL: begin
          // The dispatcher's registered decision is ready on the 2nd cycle.
          if (!ctl_cnt) begin
            ctl_cnt <= 1'b1;
          end else begin
            ctl_cnt <= 1'b0;
            if (drop) begin
              flush_q <= 1'b1;
              state_q <= DROP;
            end else begin
              rep_cnt <= hdr_cnt;
              state_q <= SEND_ANALYSED_DATA;
            end
          end
        end
        SEND_ANALYSED_DATA: begin
          if (out_xfer) begin
            rep_cnt <= rep_cnt - 4'd1;
            if (rep_cnt == 4'd1) begin
              if (short_pkt) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
                state_q   <= IDLE;
              end else begin
                state_q <= SEND_REMAIN;
              end
            end
          end
        end
        SEND_REMAIN: begin
          if (in_xfer && in_tlast) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            state_q   <= IDLE;
          end
        end
        DROP: begin
          if (short_pkt || (in_xfer && in_tlast)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hdr_flush  = flush_q;
  assign state      = state_q;
  assign busy       = (state_q != IDLE);
  assign pkt_count  = pkt_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_mat_packet_sequencer.sv
// Bench for mat_packet_sequencer: a header-buffer/output-mux environment
// model, a packet-level scoreboard and directed plus randomized packets.
module tb_mat_packet_sequencer;

  localparam int          HB      = 5;
  localparam logic [31:0] PRELOAD = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        in_tvalid;
  logic        in_tlast;
  logic        drop;
  logic        m_axis_tready;
  logic [31:0] in_tdata;

  logic        in_tready, hdr_wr, hdr_rd, hdr_sel, hdr_flush;
  logic        m_axis_tvalid, m_axis_tlast, busy;
  logic [2:0]  state;
  logic [31:0] pkt_count, drop_count;

  logic        w_in_tready, w_hdr_wr, w_hdr_rd, w_hdr_sel, w_hdr_flush;
  logic        w_m_axis_tvalid, w_m_axis_tlast, w_busy;
  logic [2:0]  w_state;
  logic [31:0] w_pkt_count, w_drop_count;

  int          n_checks;
  int          n_fail;
  logic [32:0] exp_q[$];       // {tlast, data} expected on egress
  logic [31:0] hb_q[$];        // header buffer contents
  logic [2:0]  st_log[$];
  bit          logging;
  bit          log_done;
  int          flush_cnt;
  int          viol_cnt;
  int          rmode;
  logic [31:0] exp_pkt;
  logic [31:0] exp_drop;

  mat_packet_sequencer #(.HEADER_BEATS(HB)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(in_tready),
    .drop(drop), .hdr_wr(hdr_wr), .hdr_rd(hdr_rd), .hdr_sel(hdr_sel),
    .hdr_flush(hdr_flush), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .state(state), .busy(busy), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  // Second instance with preloaded counters to exercise 32-bit wrap.
  mat_packet_sequencer #(
    .HEADER_BEATS(HB), .PKT_COUNT_RESET(PRELOAD), .DROP_COUNT_RESET(PRELOAD)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tready(w_in_tready),
    .drop(drop), .hdr_wr(w_hdr_wr), .hdr_rd(w_hdr_rd), .hdr_sel(w_hdr_sel),
    .hdr_flush(w_hdr_flush), .m_axis_tvalid(w_m_axis_tvalid),
    .m_axis_tlast(w_m_axis_tlast), .m_axis_tready(m_axis_tready),
    .state(w_state), .busy(w_busy), .pkt_count(w_pkt_count),
    .drop_count(w_drop_count)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Egress ready pattern: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0)      m_axis_tready = 1'b1;
      else if (rmode == 1) m_axis_tready = !m_axis_tready;
      else                 m_axis_tready = ($urandom_range(1, 0) == 1);
    end
  end

  // Environment + scoreboard: header buffer, output mux, egress checking.
  always @(negedge clk) begin
    logic [31:0] eg;
    logic [32:0] e;
    if (!rst_n) begin
      hb_q.delete();
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (hdr_sel && hb_q.size() == 0) begin
          check_val("hb_underflow", 32'd1, 32'd0);
        end else begin
          eg = hdr_sel ? hb_q[0] : in_tdata;
          if (exp_q.size() == 0) begin
            check_val("egress_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_val("egress_data", eg, e[31:0]);
            check_val("egress_tlast", 32'(m_axis_tlast), 32'(e[32]));
          end
        end
      end
      if (hdr_rd && !m_axis_tready) viol_cnt++;
      if (state == 3'd4 && in_tvalid && in_tready && !m_axis_tready) viol_cnt++;
      if (hdr_rd && hb_q.size() > 0) void'(hb_q.pop_front());
      if (hdr_wr) hb_q.push_back(in_tdata);
      if (hdr_flush) begin
        flush_cnt++;
        hb_q.delete();
      end
      if (logging && !log_done) begin
        if (state != 3'd0) st_log.push_back(state);
        else if (st_log.size() > 0) begin
          st_log.push_back(3'd0);
          log_done = 1'b1;
        end
      end
    end
  end

  task automatic check_quiescent(input logic [31:0] exp_cnt);
    check_val("idle_outputs",
              {16'd0, in_tready, hdr_wr, hdr_rd, hdr_sel, hdr_flush,
               m_axis_tvalid, m_axis_tlast, busy,
               w_in_tready, w_hdr_wr, w_hdr_rd, w_hdr_sel, w_hdr_flush,
               w_m_axis_tvalid, w_m_axis_tlast, w_busy}, 32'd0);
    check_val("idle_state", {26'd0, w_state, state}, 32'd0);
    check_val("idle_pkt_count", pkt_count, exp_cnt);
    check_val("idle_drop_count", drop_count, exp_cnt);
    check_val("idle_wrap_pkt_count", w_pkt_count, exp_cnt + PRELOAD);
  endtask

  // Expected state trace for an undisturbed forwarded packet.
  task automatic check_trace(input int len);
    logic [2:0] exp_tr[$];
    int hl;
    hl = (len < HB) ? len : HB;
    for (int i = 0; i < hl; i++) exp_tr.push_back(3'd1);
    exp_tr.push_back(3'd2);
    exp_tr.push_back(3'd2);
    for (int i = 0; i < hl; i++) exp_tr.push_back(3'd3);
    for (int i = 0; i < len - HB; i++) exp_tr.push_back(3'd4);
    exp_tr.push_back(3'd0);
    check_val("trace_len", 32'(st_log.size()), 32'(exp_tr.size()));
    for (int i = 0; i < exp_tr.size() && i < st_log.size(); i++)
      check_val("trace_state", 32'(st_log[i]), 32'(exp_tr[i]));
  endtask

  // Drive one packet and check its packet-level outcome.
  task automatic send_packet(input int len, input bit drp, input int gap_pct,
                             input int en_delay, input bit en_off);
    logic [31:0] beats[$];
    int n;
    int f0;
    int stuck;
    int sr_cycles;
    bit acc;
    for (int i = 0; i < len; i++) beats.push_back($urandom);
    if (!drp)
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), beats[i]});
    drop = drp;
    f0 = flush_cnt;
    st_log.delete();
    log_done = 1'b0;
    logging = 1'b1;

    if (en_delay > 0) begin
      enable = 1'b0;
      in_tvalid = 1'b1;
      in_tdata = beats[0];
      in_tlast = (len == 1);
      stuck = 0;
      repeat (en_delay) begin
        @(negedge clk);
        if (state != 3'd0 || in_tready) stuck++;
        @(posedge clk);
        #1;
      end
      check_val("enable_hold_idle", 32'(stuck), 32'd0);
      enable = 1'b1;
      @(posedge clk);
      #1;
      check_val("enable_start", 32'(state), 32'd1);
    end else begin
      enable = 1'b1;
    end

    for (int i = 0; i < len; i++) begin
      if (i > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
        in_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_tvalid = 1'b1;
      in_tdata = beats[i];
      in_tlast = (i == len - 1);
      n = 0;
      do begin
        @(negedge clk);
        acc = in_tready;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 200);
      if (!acc) begin
        check_val("beat_accept_timeout", 32'd0, 32'd1);
        break;
      end
      if (i == 0 && en_off) enable = 1'b0;
    end
    in_tvalid = 1'b0;
    in_tlast = 1'b0;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    check_val("return_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    logging = 1'b0;

    if (drp) exp_drop = exp_drop + 32'd1;
    else     exp_pkt  = exp_pkt + 32'd1;
    check_val("pkt_count", pkt_count, exp_pkt);
    check_val("drop_count", drop_count, exp_drop);
    check_val("wrap_pkt_count", w_pkt_count, exp_pkt + PRELOAD);
    check_val("wrap_drop_count", w_drop_count, exp_drop + PRELOAD);
    check_val("flush_pulses", 32'(flush_cnt - f0), 32'(drp));
    check_val("egress_left", 32'(exp_q.size()), 32'd0);
    if (len <= HB) begin
      sr_cycles = 0;
      foreach (st_log[k]) if (st_log[k] == 3'd4) sr_cycles++;
      check_val("short_skips_remain", 32'(sr_cycles), 32'd0);
    end
  endtask

  // Main sequence
  initial begin
    logic [31:0] rb[$];
    logic [2:0]  st;
    bit          acc;
    int          i;
    int          n;
    n_checks = 0;
    n_fail = 0;
    flush_cnt = 0;
    viol_cnt = 0;
    logging = 1'b0;
    log_done = 1'b0;
    rmode = 0;
    exp_pkt = '0;
    exp_drop = '0;
    rst_n = 1'b0;
    enable = 1'b0;
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    in_tdata = '0;
    drop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiescent(32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 8-beat forward with full trace, then drop, short, toggled ready
    send_packet(8, 1'b0, 0, 0, 1'b0);
    check_trace(8);
    send_packet(8, 1'b1, 0, 0, 1'b0);
    send_packet(3, 1'b0, 0, 0, 1'b0);
    check_trace(3);
    rmode = 1;
    send_packet(8, 1'b0, 0, 0, 1'b0);
    rmode = 0;
    send_packet(1, 1'b0, 0, 0, 1'b0);
    check_trace(1);
    send_packet(1, 1'b1, 0, 0, 1'b0);
    send_packet(5, 1'b0, 0, 0, 1'b0);
    send_packet(6, 1'b1, 0, 0, 1'b1);
    send_packet(2, 1'b0, 0, 3, 1'b0);

    // Asynchronous reset in the middle of SEND_REMAIN
    for (int k = 0; k < 8; k++) rb.push_back($urandom);
    for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7), rb[k]});
    drop = 1'b0;
    enable = 1'b1;
    i = 0;
    in_tvalid = 1'b1;
    in_tdata = rb[0];
    in_tlast = 1'b0;
    n = 0;
    st = 3'd0;
    while (n < 100) begin
      @(negedge clk);
      acc = in_tready;
      st = state;
      if (st == 3'd4) break;
      @(posedge clk);
      #1;
      n++;
      if (acc && i < 7) begin
        i++;
        in_tdata = rb[i];
        in_tlast = (i == 7);
      end
    end
    check_val("reach_send_remain", 32'(st), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    exp_pkt = '0;
    exp_drop = '0;
    check_quiescent(32'd0);
    in_tvalid = 1'b0;
    in_tlast = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_packet(7, 1'b0, 0, 0, 1'b0);

    // Randomized packets
    for (int p = 0; p < 40; p++) begin
      rmode = int'($urandom_range(2, 0));
      send_packet(int'($urandom_range(12, 1)), ($urandom_range(9, 0) < 3),
                  int'($urandom_range(30, 0)), int'($urandom_range(2, 0)),
                  ($urandom_range(1, 0) == 1));
    end

    check_val("ready_violations", 32'(viol_cnt), 32'd0);
    check_val("egress_final_left", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mat_packet_sequencer.md
Name: mat_packet_sequencer

Overview:
- Per-packet controller for the MAT ingress path. Generates the 3-bit `state` consumed by the packet dispatcher and parser.
- Gates the ingress stream into a header buffer, replays the buffered header beats downstream, then passes the packet remainder through or discards it.
- Sits between the ingress AXIS port and the mat header buffer/output mux. Uses the dispatcher's registered `drop` decision.

Parameters:
- HEADER_BEATS, 5, beats captured and parsed before the decision (Ethernet + IPv4 headers at 64-bit width); range 1..15.
- IDLE/PARSE_DATA/CONTROL/SEND_ANALYSED_DATA/SEND_REMAIN/DROP, 0/1/2/3/4/5, `state` encodings shared with the dispatcher.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits starting a new packet; sampled only in IDLE
- in_tvalid  in  1  ingress beat valid
- in_tlast  in  1  ingress last beat
- in_tready  out  1  ingress ready
- drop  in  1  dispatcher decision; valid one cycle after `state` enters CONTROL
- hdr_wr  out  1  write the current ingress beat into the header buffer
- hdr_rd  out  1  pop a header buffer beat; header buffer drives output data
- hdr_sel  out  1  output mux: 1 = header buffer, 0 = live ingress
- hdr_flush  out  1  one-cycle pulse that empties the header buffer
- m_axis_tvalid  out  1  egress valid
- m_axis_tlast  out  1  egress last
- m_axis_tready  in  1  egress ready
- state  out  3  current FSM state
- busy  out  1  state != IDLE
- pkt_count  out  32  packets fully forwarded; wraps
- drop_count  out  32  packets dropped; wraps

Behaviour:
- Reset: state=IDLE, all counters 0, all outputs 0. Reset asserted mid-packet aborts immediately. The header buffer is not flushed by this block in that case; it is reset by the same rst_n.
- All handshakes are standard AXIS: a transfer occurs when valid && ready.
- IDLE:
  - in_tready=0.
  - If enable && in_tvalid: go to PARSE_DATA, clear hdr_cnt (4 bits) and short flag.
- PARSE_DATA:
  - in_tready=1; hdr_wr = in_tvalid.
  - Each accepted beat increments hdr_cnt.
  - If the accepted beat has in_tlast=1: set short=1 and go to CONTROL.
  - Otherwise go to CONTROL when hdr_cnt reaches HEADER_BEATS.
- CONTROL:
  - Lasts exactly 2 cycles (ctl_cnt); in_tready=0.
  - `drop` is sampled on the 2nd cycle.
  - drop=1: go to DROP and pulse hdr_flush.
  - drop=0: go to SEND_ANALYSED_DATA with rep_cnt = hdr_cnt.
- SEND_ANALYSED_DATA:
  - hdr_sel=1; m_axis_tvalid = (rep_cnt != 0); hdr_rd = m_axis_tvalid && m_axis_tready; in_tready=0.
  - Each pop decrements rep_cnt.
  - m_axis_tlast = short && rep_cnt==1.
  - On the last pop: if short, go to IDLE and increment pkt_count; else go to SEND_REMAIN.
- SEND_REMAIN:
  - hdr_sel=0; m_axis_tvalid = in_tvalid; in_tready = m_axis_tready; m_axis_tlast = in_tlast.
  - A transfer with in_tlast: go to IDLE and increment pkt_count.
- DROP:
  - If short: go to IDLE next cycle and increment drop_count.
  - Else: in_tready=1, m_axis_tvalid=0. A transfer with in_tlast: go to IDLE and increment drop_count.
- Combinational paths:
  - in_tready depends on m_axis_tready only in SEND_REMAIN.
  - m_axis_tvalid never depends on m_axis_tready.
- enable deasserted mid-packet does not abort; it takes effect at the next IDLE.
- A single-beat packet (tlast on the first beat) follows PARSE_DATA → CONTROL → SEND_ANALYSED_DATA (1 beat, tlast=1) → IDLE.
- Counters are 32-bit and wrap from 0xFFFFFFFF to 0.

Test Plan:
- 8-beat packet, drop=0, m_axis_tready=1 → states 1,2,2,3×5,4×3,0; 8 egress beats; tlast only on beat 8; pkt_count=1.
- 8-beat packet, drop=1 → hdr_flush pulses once; no egress beats; 3 remaining beats consumed with in_tready=1; drop_count=1; pkt_count=0.
- 3-beat packet (tlast on beat 3), drop=0 → SEND_REMAIN is skipped; 3 egress beats with tlast on the 3rd; returns to IDLE; pkt_count=1.
- 8-beat packet, m_axis_tready toggling 1/0 every cycle → no hdr_rd or in transfer while ready=0; beat order is preserved; total 8 beats.
- rst_n low while in SEND_REMAIN → state=IDLE and all outputs 0 within the same cycle (asynchronous); next packet with enable=1 processed normally.
- enable=0 with in_tvalid=1 → stays IDLE, in_tready=0; enable=1 → PARSE_DATA next cycle. Preload pkt_count=0xFFFFFFFF, forward one packet → pkt_count=0.
